// File: rtl/pipeline_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_sequencer
//
// Carries the per-instruction control bundle decoded in ID through the EX,
// MEM and WB control registers. It also generates the front-end write enables
// and the IF/ID flush. Bubbles are inserted for three cases:
//   - load-use hazards (one cycle),
//   - multi-cycle multiplies (EX held for MULT_LAT cycles in total),
//   - taken branches/jumps resolved in EX (ID squashed).
//
// Parameters
//   MULT_LAT          cycles a multiply occupies EX (>=1, 1 = no hold)
//
// Ports
//   Clk, Rst          clock (rising edge), synchronous active-high reset
//   ID_*              control bundle and register numbers of the ID instruction
//   EX_BranchTaken    branch/jump in EX resolved taken
//   PC_WriteEnable    PC may update
//   IFID_WriteEnable  IF/ID register may update
//   IFID_Flush        squash IF/ID contents
//   StageWriteEnable  [0] ID/EX, [1] EX/MEM, [2] MEM/WB write enables
//   EX/MEM/WB_Valid   stage holds a real instruction
//   MEM_MemRead/Write gated memory strobes, MEM_ByteSel access size
//   WB_RegWrite       gated register-file write
//   WB_MemToReg       writeback source select
//   WB_Dst            writeback register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_ctrl_sequencer #(
  parameter int MULT_LAT = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ID_Valid,
  input  logic       ID_RegWrite,
  input  logic       ID_MemRead,
  input  logic       ID_MemWrite,
  input  logic [1:0] ID_MemToReg,
  input  logic [1:0] ID_ByteSel,
  input  logic       ID_Mult,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic [4:0] ID_Dst,
  input  logic       EX_BranchTaken,
  output logic       PC_WriteEnable,
  output logic       IFID_WriteEnable,
  output logic       IFID_Flush,
  output logic [2:0] StageWriteEnable,
  output logic       EX_Valid,
  output logic       MEM_Valid,
  output logic       WB_Valid,
  output logic       MEM_MemRead,
  output logic       MEM_MemWrite,
  output logic [1:0] MEM_ByteSel,
  output logic       WB_RegWrite,
  output logic [1:0] WB_MemToReg,
  output logic [4:0] WB_Dst
);

  // Counter holds MULT_LAT-2 down to 0; keep at least one bit for small latencies.
  localparam int CNT_W = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MULT_LAT > 2) ? CNT_W'(MULT_LAT - 2) : '0;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // EX stage control register
  logic       vld_p0;
  logic       regwrite_p0;
  logic       memread_p0;
  logic       memwrite_p0;
  logic [1:0] memtoreg_p0;
  logic [1:0] bytesel_p0;
  logic       mult_p0;
  logic [4:0] dst_p0;

  // MEM stage control register
  logic       vld_p1;
  logic       regwrite_p1;
  logic       memread_p1;
  logic       memwrite_p1;
  logic [1:0] memtoreg_p1;
  logic [1:0] bytesel_p1;
  logic [4:0] dst_p1;

  // WB stage control register
  logic       vld_p2;
  logic       regwrite_p2;
  logic [1:0] memtoreg_p2;
  logic [4:0] dst_p2;

  logic branch;
  logic stall;
  logic capture;

  // A load in EX whose destination feeds the ID instruction; $0 never conflicts.
  function automatic logic load_use(
    input logic       id_vld,
    input logic       ex_vld,
    input logic       ex_memread,
    input logic [4:0] ex_dst,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return id_vld && ex_vld && ex_memread && (ex_dst != 5'd0) &&
           ((ex_dst == rs) || (ex_dst == rt));
  endfunction

  // Branch outranks load-use: the dependent instruction is squashed anyway.
  assign branch  = (state == RUN) && EX_BranchTaken && vld_p0;
  assign stall   = (state == RUN) && !branch &&
                   load_use(ID_Valid, vld_p0, memread_p0, dst_p0, ID_Rs, ID_Rt);
  assign capture = (state == RUN) && ID_Valid && !branch && !stall;

  // The FSM enters MULT_WAIT on the same edge that loads the multiply into EX,
  // so the multiply's first EX cycle is already a hold cycle. MULT_LAT-1 hold
  // cycles followed by one RUN cycle give MULT_LAT cycles of EX occupancy.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (capture && ID_Mult && (MULT_LAT > 1)) begin
            state <= MULT_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        MULT_WAIT: begin
          // Never keep holding EX once it no longer contains a multiply.
          if ((cnt == '0) || !(vld_p0 && mult_p0)) begin
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    PC_WriteEnable   = 1'b1;
    IFID_WriteEnable = 1'b1;
    IFID_Flush       = 1'b0;
    StageWriteEnable = 3'b111;
    if (Rst) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      IFID_Flush       = 1'b1;
      StageWriteEnable = 3'b000;
    end else if (state == MULT_WAIT) begin
      PC_WriteEnable      = 1'b0;
      IFID_WriteEnable    = 1'b0;
      StageWriteEnable[0] = 1'b0;
    end else if (branch) begin
      IFID_Flush = 1'b1;
    end else if (stall) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
    end
  end

  // ---- ID -> EX boundary: held during MULT_WAIT, bubble when not captured ----
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p0      <= 1'b0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
      memwrite_p0 <= 1'b0;
      memtoreg_p0 <= 2'b00;
      bytesel_p0  <= 2'b00;
      mult_p0     <= 1'b0;
      dst_p0      <= 5'd0;
    end else if (state != MULT_WAIT) begin
      if (capture) begin
        vld_p0      <= 1'b1;
        regwrite_p0 <= ID_RegWrite;
        memread_p0  <= ID_MemRead;
        memwrite_p0 <= ID_MemWrite;
        memtoreg_p0 <= ID_MemToReg;
        bytesel_p0  <= ID_ByteSel;
        mult_p0     <= ID_Mult;
        dst_p0      <= ID_Dst;
      end else begin
        vld_p0      <= 1'b0;
        regwrite_p0 <= 1'b0;
        memread_p0  <= 1'b0;
        memwrite_p0 <= 1'b0;
        memtoreg_p0 <= 2'b00;
        bytesel_p0  <= 2'b00;
        mult_p0     <= 1'b0;
        dst_p0      <= 5'd0;
      end
    end
  end

  // ---- EX -> MEM boundary: bubble while EX is held by a multiply ----
  always_ff @(posedge Clk) begin
    if (Rst || (state == MULT_WAIT)) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      memtoreg_p1 <= 2'b00;
      bytesel_p1  <= 2'b00;
      dst_p1      <= 5'd0;
    end else begin
      vld_p1      <= vld_p0;
      regwrite_p1 <= regwrite_p0;
      memread_p1  <= memread_p0;
      memwrite_p1 <= memwrite_p0;
      memtoreg_p1 <= memtoreg_p0;
      bytesel_p1  <= bytesel_p0;
      dst_p1      <= dst_p0;
    end
  end

  // ---- MEM -> WB boundary: always advances ----
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p2      <= 1'b0;
      regwrite_p2 <= 1'b0;
      memtoreg_p2 <= 2'b00;
      dst_p2      <= 5'd0;
    end else begin
      vld_p2      <= vld_p1;
      regwrite_p2 <= regwrite_p1;
      memtoreg_p2 <= memtoreg_p1;
      dst_p2      <= dst_p1;
    end
  end

  // Valids and strobes are forced low while reset is asserted.
  assign EX_Valid     = vld_p0 && !Rst;
  assign MEM_Valid    = vld_p1 && !Rst;
  assign WB_Valid     = vld_p2 && !Rst;
  assign MEM_MemRead  = vld_p1 && memread_p1 && !Rst;
  assign MEM_MemWrite = vld_p1 && memwrite_p1 && !Rst;
  assign MEM_ByteSel  = bytesel_p1;
  assign WB_RegWrite  = vld_p2 && regwrite_p2 && !Rst;
  assign WB_MemToReg  = memtoreg_p2;
  assign WB_Dst       = dst_p2;

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
`timescale 1ns/1ps

module tb_pipeline_ctrl_sequencer;

  localparam int MULT_LAT = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       ID_Valid;
  logic       ID_RegWrite;
  logic       ID_MemRead;
  logic       ID_MemWrite;
  logic [1:0] ID_MemToReg;
  logic [1:0] ID_ByteSel;
  logic       ID_Mult;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic [4:0] ID_Dst;
  logic       EX_BranchTaken;
  logic       PC_WriteEnable;
  logic       IFID_WriteEnable;
  logic       IFID_Flush;
  logic [2:0] StageWriteEnable;
  logic       EX_Valid;
  logic       MEM_Valid;
  logic       WB_Valid;
  logic       MEM_MemRead;
  logic       MEM_MemWrite;
  logic [1:0] MEM_ByteSel;
  logic       WB_RegWrite;
  logic [1:0] WB_MemToReg;
  logic [4:0] WB_Dst;

  pipeline_ctrl_sequencer #(.MULT_LAT(MULT_LAT)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .ID_Valid         (ID_Valid),
    .ID_RegWrite      (ID_RegWrite),
    .ID_MemRead       (ID_MemRead),
    .ID_MemWrite      (ID_MemWrite),
    .ID_MemToReg      (ID_MemToReg),
    .ID_ByteSel       (ID_ByteSel),
    .ID_Mult          (ID_Mult),
    .ID_Rs            (ID_Rs),
    .ID_Rt            (ID_Rt),
    .ID_Dst           (ID_Dst),
    .EX_BranchTaken   (EX_BranchTaken),
    .PC_WriteEnable   (PC_WriteEnable),
    .IFID_WriteEnable (IFID_WriteEnable),
    .IFID_Flush       (IFID_Flush),
    .StageWriteEnable (StageWriteEnable),
    .EX_Valid         (EX_Valid),
    .MEM_Valid        (MEM_Valid),
    .WB_Valid         (WB_Valid),
    .MEM_MemRead      (MEM_MemRead),
    .MEM_MemWrite     (MEM_MemWrite),
    .MEM_ByteSel      (MEM_ByteSel),
    .WB_RegWrite      (WB_RegWrite),
    .WB_MemToReg      (WB_MemToReg),
    .WB_Dst           (WB_Dst)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [1:0] m2r;
    logic [1:0] bs;
    logic       mult;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
  } id_t;

  typedef struct packed {
    logic       pcwe;
    logic       ifidwe;
    logic       flush;
    logic [2:0] swe;
    logic       exv;
    logic       memv;
    logic       wbv;
    logic       mmr;
    logic       mmw;
    logic [1:0] mbs;
    logic       wbrw;
    logic [1:0] wbm2r;
    logic [4:0] wbdst;
  } out_t;

  typedef struct {
    string tag;
    logic  rst;
    id_t   id;
    logic  br;
    out_t  exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  out_t exp_q[$];
  logic [4:0] wb_q[$];

  id_t NOP, LW5, ADD5, LW0, ADD0, ADDY, MUL, ADDX, SW;
  out_t RSTO;

  function automatic id_t mkid(input logic rw, input logic mr, input logic mw,
                               input logic [1:0] m2r, input logic [1:0] bs,
                               input logic mult, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] dst);
    id_t r;
    r.v = 1'b1; r.rw = rw; r.mr = mr; r.mw = mw; r.m2r = m2r; r.bs = bs;
    r.mult = mult; r.rs = rs; r.rt = rt; r.dst = dst;
    return r;
  endfunction

  function automatic out_t mo(input logic pcwe, input logic ifidwe, input logic flush,
                              input logic [2:0] swe, input logic exv, input logic memv,
                              input logic wbv, input logic mmr, input logic mmw,
                              input logic [1:0] mbs, input logic wbrw,
                              input logic [1:0] wbm2r, input logic [4:0] wbdst);
    out_t r;
    r.pcwe = pcwe; r.ifidwe = ifidwe; r.flush = flush; r.swe = swe;
    r.exv = exv; r.memv = memv; r.wbv = wbv; r.mmr = mmr; r.mmw = mmw;
    r.mbs = mbs; r.wbrw = wbrw; r.wbm2r = wbm2r; r.wbdst = wbdst;
    return r;
  endfunction

  // Normal-advance front-end outputs.
  function automatic out_t run(input logic exv, input logic memv, input logic wbv,
                               input logic mmr, input logic mmw, input logic [1:0] mbs,
                               input logic wbrw, input logic [1:0] wbm2r,
                               input logic [4:0] wbdst);
    return mo(1'b1, 1'b1, 1'b0, 3'b111, exv, memv, wbv, mmr, mmw, mbs, wbrw, wbm2r, wbdst);
  endfunction

  // Multiply-hold front-end outputs.
  function automatic out_t mw(input logic exv, input logic memv, input logic wbv,
                              input logic wbrw, input logic [1:0] wbm2r,
                              input logic [4:0] wbdst);
    return mo(1'b0, 1'b0, 1'b0, 3'b110, exv, memv, wbv, 1'b0, 1'b0, 2'b00, wbrw, wbm2r, wbdst);
  endfunction

  function automatic out_t sample();
    out_t s;
    s = {PC_WriteEnable, IFID_WriteEnable, IFID_Flush, StageWriteEnable,
         EX_Valid, MEM_Valid, WB_Valid, MEM_MemRead, MEM_MemWrite, MEM_ByteSel,
         WB_RegWrite, WB_MemToReg, WB_Dst};
    return s;
  endfunction

  task automatic add(input string tag, input logic rst, input id_t id, input logic br,
                     input out_t e);
    vec_t r;
    r.tag = tag; r.rst = rst; r.id = id; r.br = br; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic rst, input id_t id, input logic br);
    Rst            = rst;
    ID_Valid       = id.v;
    ID_RegWrite    = id.rw;
    ID_MemRead     = id.mr;
    ID_MemWrite    = id.mw;
    ID_MemToReg    = id.m2r;
    ID_ByteSel     = id.bs;
    ID_Mult        = id.mult;
    ID_Rs          = id.rs;
    ID_Rt          = id.rt;
    ID_Dst         = id.dst;
    EX_BranchTaken = br;
  endtask

  initial begin
    out_t z;
    out_t act;
    out_t e;
    id_t  prog[6];
    int   pc;
    int   stalls;
    int   cyc;

    NOP  = '0;
    LW5  = mkid(1, 1, 0, 2'b01, 2'b00, 0, 5'd1, 5'd0, 5'd5);
    ADD5 = mkid(1, 0, 0, 2'b00, 2'b00, 0, 5'd5, 5'd2, 5'd6);
    LW0  = mkid(1, 1, 0, 2'b01, 2'b00, 0, 5'd1, 5'd0, 5'd0);
    ADD0 = mkid(1, 0, 0, 2'b00, 2'b00, 0, 5'd0, 5'd3, 5'd7);
    ADDY = mkid(1, 0, 0, 2'b00, 2'b00, 0, 5'd1, 5'd2, 5'd11);
    MUL  = mkid(1, 0, 0, 2'b10, 2'b00, 1, 5'd2, 5'd3, 5'd9);
    ADDX = mkid(1, 0, 0, 2'b00, 2'b00, 0, 5'd9, 5'd1, 5'd10);
    SW   = mkid(0, 0, 1, 2'b00, 2'b01, 0, 5'd4, 5'd8, 5'd0);
    RSTO = mo(0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0);
    z    = run(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0);

    // reset and release
    add("reset0",  1, NOP,  0, RSTO);
    add("reset1",  1, NOP,  0, RSTO);
    add("release", 0, NOP,  0, z);
    // load-use on $5, then the same pattern on $0
    add("lu_lw",   0, LW5,  0, z);
    add("lu_stall",0, ADD5, 0, mo(0, 0, 0, 3'b111, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("lu_bub",  0, ADD5, 0, run(0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 5'd0));
    add("lu_wb",   0, NOP,  0, run(1, 0, 1, 0, 0, 2'b00, 1, 2'b01, 5'd5));
    add("r0_lw",   0, LW0,  0, run(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("r0_nost", 0, ADD0, 0, run(1, 0, 1, 0, 0, 2'b00, 1, 2'b00, 5'd6));
    add("r0_adv",  0, NOP,  0, run(1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 5'd0));
    add("r0_wb",   0, NOP,  0, run(0, 1, 1, 0, 0, 2'b00, 1, 2'b01, 5'd0));
    // multiply hold with a valid instruction ahead of it
    add("m_pre",   0, ADDY, 0, run(0, 0, 1, 0, 0, 2'b00, 1, 2'b00, 5'd7));
    add("m_id",    0, MUL,  0, run(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("m_hold1", 0, ADDX, 0, mw(1, 1, 0, 0, 2'b00, 5'd0));
    add("m_hold2", 0, ADDX, 0, mw(1, 0, 1, 1, 2'b00, 5'd11));
    add("m_hold3", 0, ADDX, 0, mw(1, 0, 0, 0, 2'b00, 5'd0));
    add("m_last",  0, ADDX, 0, run(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("m_mem",   0, NOP,  0, run(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("m_wb",    0, NOP,  0, run(0, 1, 1, 0, 0, 2'b00, 1, 2'b10, 5'd9));
    add("m_next",  0, NOP,  0, run(0, 0, 1, 0, 0, 2'b00, 1, 2'b00, 5'd10));
    // taken branch outranks load-use; unqualified branch is ignored
    add("b_lw",    0, LW5,  0, z);
    add("b_flush", 0, ADD5, 1, mo(1, 1, 1, 3'b111, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("b_noex",  0, NOP,  1, run(0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 5'd0));
    add("b_wb",    0, NOP,  0, run(0, 0, 1, 0, 0, 2'b00, 1, 2'b01, 5'd5));
    // reset in the second multiply-hold cycle; branch ignored while held
    add("rm_id",   0, MUL,  0, z);
    add("rm_h1br", 0, ADDX, 1, mw(1, 0, 0, 0, 2'b00, 5'd0));
    add("rm_rst",  1, ADDX, 0, RSTO);
    add("rm_rel",  0, ADDX, 0, z);
    add("rm_ex",   0, NOP,  0, run(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("rm_mem",  0, NOP,  0, run(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("rm_wb",   0, NOP,  0, run(0, 0, 1, 0, 0, 2'b00, 1, 2'b00, 5'd10));
    // byte store
    add("sw_id",   0, SW,   0, z);
    add("sw_ex",   0, NOP,  0, run(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("sw_mem",  0, NOP,  0, run(0, 1, 0, 0, 1, 2'b01, 0, 2'b00, 5'd0));
    add("sw_wb",   0, NOP,  0, run(0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 5'd0));
    add("sw_done", 0, NOP,  0, z);

    drive(1'b1, NOP, 1'b0);

    foreach (tbl[i]) begin
      @(posedge Clk);
      #1;
      drive(tbl[i].rst, tbl[i].id, tbl[i].br);
      exp_q.push_back(tbl[i].exp);
      @(negedge Clk);
      e   = exp_q.pop_front();
      act = sample();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s (row %0d): got pcwe/ifwe/fl/swe/exv/memv/wbv/mr/mw/bs/rw/m2r/dst=%b required %b",
                 tbl[i].tag, i, act, e);
      end
    end

    // Program run with a bench-side IF stage: an instruction leaves ID only
    // when IF/ID is written and not flushed; each register writer's Dst is
    // queued at that point and must come back on WB_RegWrite in order.
    prog[0] = LW5;
    prog[1] = ADD5;
    prog[2] = MUL;
    prog[3] = ADDX;
    prog[4] = SW;
    prog[5] = ADDY;
    pc     = 0;
    stalls = 0;
    cyc    = 0;
    while (!(pc == 6 && wb_q.size() == 0) && cyc < 60) begin
      @(posedge Clk);
      #1;
      drive(1'b0, (pc < 6) ? prog[pc] : NOP, 1'b0);
      @(negedge Clk);
      cyc++;
      if (WB_RegWrite) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL prog_wb: unexpected write to r%0d, none required", WB_Dst);
        end else begin
          logic [4:0] want;
          want = wb_q.pop_front();
          if (WB_Dst !== want) begin
            errors++;
            $display("FAIL prog_wb: WB_Dst=%0d required %0d", WB_Dst, want);
          end
        end
      end
      if (!PC_WriteEnable) stalls++;
      if (IFID_WriteEnable && !IFID_Flush && pc < 6) begin
        if (prog[pc].rw) wb_q.push_back(prog[pc].dst);
        pc++;
      end
    end

    checks++;
    if (!(pc == 6 && wb_q.size() == 0)) begin
      errors++;
      $display("FAIL prog_done: issued=%0d pending=%0d after %0d cycles, required 6 issued 0 pending",
               pc, wb_q.size(), cyc);
    end
    // one load-use cycle plus MULT_LAT-1 multiply-hold cycles
    checks++;
    if (stalls != 1 + (MULT_LAT - 1)) begin
      errors++;
      $display("FAIL prog_stalls: PC hold cycles=%0d required %0d", stalls, 1 + (MULT_LAT - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
